// File: rtl/simd_wb_merge.sv
// Writeback merge: arbitrates/coalesces FPU vector results and FP load results into one regfile row write.
// Latency: load accepted in N -> write in N+1; FPU accepted in N -> write in N+2 at the earliest.
// Backpressure: fpu_ready_o drops when the 2-entry FIFO is full; ld_ready_o drops only on a forced FPU cycle.
module simd_wb_merge #(
  parameter int width_p        = 32,
  parameter int els_p          = 32,
  parameter int starve_limit_p = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      fpu_v_i,
  output logic                      fpu_ready_o,
  input  logic [2:0]                fpu_row_i,
  input  logic [3:0]                fpu_mask_i,
  input  logic [4*width_p-1:0]      fpu_data_i,
  input  logic                      ld_v_i,
  output logic                      ld_ready_o,
  input  logic [$clog2(els_p)-1:0]  ld_addr_i,
  input  logic [width_p-1:0]        ld_data_i,
  output logic [3:0]                w_v_o,
  output logic [$clog2(els_p)-1:0]  w_addr_o,
  output logic [4*width_p-1:0]      w_data_o
);

  localparam int          AddrW     = $clog2(els_p);
  localparam int          RowW      = AddrW - 2;
  localparam int          DataW     = 4 * width_p;
  localparam logic [3:0]  StarveLim = 4'(starve_limit_p);

  typedef struct packed {
    logic [RowW-1:0]  row;
    logic [3:0]       mask;
    logic [DataW-1:0] data;
  } fpu_ent_t;

  // FPU FIFO state
  fpu_ent_t   fifo_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] cnt_q, cnt_d;

  // Starvation counter and output register
  logic [3:0]       starve_q, starve_d;
  logic [3:0]       w_v_q;
  logic [AddrW-1:0] w_addr_q;
  logic [DataW-1:0] w_data_q;

  // Arbiter signals
  fpu_ent_t         head;
  logic             head_v;
  logic             forced;
  logic             ld_req;
  logic [1:0]       ld_lane;
  logic [RowW-1:0]  ld_row;
  logic [3:0]       ld_onehot;
  logic             can_merge;
  logic             fpu_push;
  logic             pop;
  logic             sel;
  logic [3:0]       sel_en;
  logic [AddrW-1:0] sel_addr;
  logic [DataW-1:0] sel_data;

  // Ready flags come only from registered state so they never loop through a valid input.
  assign fpu_ready_o = (cnt_q != 2'd2);
  assign forced      = (starve_q == StarveLim);
  assign ld_ready_o  = ~forced;

  assign fpu_push  = fpu_v_i & fpu_ready_o;
  assign head      = fifo_q[rd_ptr_q];
  assign head_v    = (cnt_q != 2'd0);
  assign ld_req    = ld_v_i & ld_ready_o;
  assign ld_lane   = ld_addr_i[1:0];
  assign ld_row    = ld_addr_i[AddrW-1:2];
  assign ld_onehot = 4'b0001 << ld_lane;
  assign can_merge = head_v & ld_req & (ld_row == head.row) & ~head.mask[ld_lane];

  // Pick the write for this cycle: merge if lanes are disjoint, else the load wins, else the FIFO head.
  always_comb begin
    sel      = 1'b0;
    pop      = 1'b0;
    sel_en   = 4'b0000;
    sel_addr = w_addr_q;
    sel_data = w_data_q;
    if (can_merge) begin
      sel      = 1'b1;
      pop      = 1'b1;
      sel_en   = head.mask | ld_onehot;
      sel_addr = {head.row, 2'b00};
      sel_data = head.data;
      for (int i = 0; i < 4; i++) begin
        if (ld_lane == i[1:0]) begin
          sel_data[i*width_p +: width_p] = ld_data_i;
        end
      end
    end else if (ld_req) begin
      sel      = 1'b1;
      sel_en   = ld_onehot;
      sel_addr = ld_addr_i;
      sel_data = {4{ld_data_i}};
    end else if (head_v) begin
      // A zero mask still pops here; it simply yields no lane enables.
      sel      = 1'b1;
      pop      = 1'b1;
      sel_en   = head.mask;
      sel_addr = {head.row, 2'b00};
      sel_data = head.data;
    end
  end

  // Occupancy and starvation next-state.
  always_comb begin
    cnt_d = cnt_q + {1'b0, fpu_push} - {1'b0, pop};
    starve_d = starve_q;
    if (!head_v || pop) begin
      starve_d = 4'd0;
    end else if (starve_q != StarveLim) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // FIFO storage and pointers; a push never targets the head slot since full blocks pushes.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (fpu_push) begin
        fifo_q[wr_ptr_q] <= '{row: fpu_row_i, mask: fpu_mask_i, data: fpu_data_i};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  // Starvation counter: counts consecutive cycles the FIFO head was passed over.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Output register: enables reload every cycle, address/data only when something was selected.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      w_v_q    <= 4'b0000;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      w_v_q <= sel_en;
      if (sel) begin
        w_addr_q <= sel_addr;
        w_data_q <= sel_data;
      end
    end
  end

  assign w_v_o    = w_v_q;
  assign w_addr_o = w_addr_q;
  assign w_data_o = w_data_q;

endmodule

// File: tb/tb_simd_wb_merge.sv
// Scoreboarded directed bench for simd_wb_merge with default parameters.
module tb_simd_wb_merge;

  localparam int W = 32;

  logic           clk_i = 1'b0;
  logic           reset_n_i = 1'b0;
  logic           fpu_v_i = 1'b0;
  logic           fpu_ready_o;
  logic [2:0]     fpu_row_i = '0;
  logic [3:0]     fpu_mask_i = '0;
  logic [4*W-1:0] fpu_data_i = '0;
  logic           ld_v_i = 1'b0;
  logic           ld_ready_o;
  logic [4:0]     ld_addr_i = '0;
  logic [W-1:0]   ld_data_i = '0;
  logic [3:0]     w_v_o;
  logic [4:0]     w_addr_o;
  logic [4*W-1:0] w_data_o;

  simd_wb_merge #(.width_p(W), .els_p(32), .starve_limit_p(4)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .fpu_v_i(fpu_v_i), .fpu_ready_o(fpu_ready_o), .fpu_row_i(fpu_row_i),
    .fpu_mask_i(fpu_mask_i), .fpu_data_i(fpu_data_i),
    .ld_v_i(ld_v_i), .ld_ready_o(ld_ready_o), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i),
    .w_v_o(w_v_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]     v;
    logic [4:0]     a;
    logic [4*W-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic logic [4*W-1:0] pack4(input logic [W-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string name, input logic [4*W-1:0] act, input logic [4*W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_wr(input logic [3:0] v, input logic [4:0] a, input logic [4*W-1:0] d);
    exp_t e;
    e.v = v; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_fpu(input logic v, input logic [2:0] row, input logic [3:0] mask,
                           input logic [4*W-1:0] data);
    fpu_v_i = v; fpu_row_i = row; fpu_mask_i = mask; fpu_data_i = data;
  endtask

  task automatic drive_ld(input logic v, input logic [4:0] addr, input logic [W-1:0] data);
    ld_v_i = v; ld_addr_i = addr; ld_data_i = data;
  endtask

  // Monitor: every non-zero write must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (reset_n_i && w_v_o != 4'b0000) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got v=%b addr=%0d expected no write", w_v_o, w_addr_o);
        end else begin
          e = exp_q.pop_front();
          chk("wr_v", {124'b0, w_v_o}, {124'b0, e.v});
          chk("wr_addr", {123'b0, w_addr_o}, {123'b0, e.a});
          chk("wr_data", w_data_o, e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4*W-1:0] dE, dF, dG, dH;
    // Reset
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_w_v", {124'b0, w_v_o}, '0);
    chk("rst_w_addr", {123'b0, w_addr_o}, '0);
    chk("rst_w_data", w_data_o, '0);
    reset_n_i = 1'b1;
    tick();
    chk("rst_fpu_ready", {127'b0, fpu_ready_o}, 128'd1);
    chk("rst_ld_ready", {127'b0, ld_ready_o}, 128'd1);

    // Single load to element 6
    drive_ld(1'b1, 5'd6, 32'hA);
    expect_wr(4'b0100, 5'd6, pack4(32'hA, 32'hA, 32'hA, 32'hA));
    tick();
    drive_ld(1'b0, 5'd0, 32'h0);
    chk("ld_latency_v", {124'b0, w_v_o}, {124'b0, 4'b0100});
    tick();
    chk("ld_then_idle_v", {124'b0, w_v_o}, '0);

    // FPU row 3 mask 1011, load path idle
    drive_fpu(1'b1, 3'd3, 4'b1011, pack4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444));
    expect_wr(4'b1011, 5'd12, pack4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444));
    tick();
    drive_fpu(1'b0, 3'd0, 4'b0000, '0);
    chk("fpu_lat_n1_v", {124'b0, w_v_o}, '0);
    tick();
    chk("fpu_lat_n2_v", {124'b0, w_v_o}, {124'b0, 4'b1011});
    tick();

    // Merge: head row 2 mask 0011 + load to element 10 (row 2 lane 2)
    dE = pack4(32'hE0, 32'hE1, 32'hE2, 32'hE3);
    drive_fpu(1'b1, 3'd2, 4'b0011, dE);
    tick();
    drive_fpu(1'b0, 3'd0, 4'b0000, '0);
    drive_ld(1'b1, 5'd10, 32'hCAFE);
    chk("merge_ld_ready", {127'b0, ld_ready_o}, 128'd1);
    expect_wr(4'b0111, 5'd8, pack4(32'hE0, 32'hE1, 32'hCAFE, 32'hE3));
    tick();
    drive_ld(1'b0, 5'd0, 32'h0);
    tick();
    chk("merge_single_write_v", {124'b0, w_v_o}, '0);

    // Conflict: head row 2 mask 0100 + load to element 10
    dF = pack4(32'hF0, 32'hF1, 32'hF2, 32'hF3);
    drive_fpu(1'b1, 3'd2, 4'b0100, dF);
    tick();
    drive_fpu(1'b0, 3'd0, 4'b0000, '0);
    drive_ld(1'b1, 5'd10, 32'hBEEF);
    expect_wr(4'b0100, 5'd10, pack4(32'hBEEF, 32'hBEEF, 32'hBEEF, 32'hBEEF));
    expect_wr(4'b0100, 5'd8, dF);
    tick();
    drive_ld(1'b0, 5'd0, 32'h0);
    tick();
    tick();

    // Starvation: head row 1 mask 0001, loads hammer element 4
    dG = pack4(32'h6000, 32'h6001, 32'h6002, 32'h6003);
    drive_fpu(1'b1, 3'd1, 4'b0001, dG);
    tick();
    drive_fpu(1'b0, 3'd0, 4'b0000, '0);
    for (int i = 0; i < 4; i++) begin
      drive_ld(1'b1, 5'd4, 32'h100 + 32'(i));
      chk("starve_ld_ready_hi", {127'b0, ld_ready_o}, 128'd1);
      expect_wr(4'b0001, 5'd4, {4{32'h100 + 32'(i)}});
      tick();
    end
    drive_ld(1'b1, 5'd4, 32'h1FF);
    chk("starve_forced_ld_ready", {127'b0, ld_ready_o}, '0);
    expect_wr(4'b0001, 5'd4, dG);
    tick();
    chk("starve_cleared_ld_ready", {127'b0, ld_ready_o}, 128'd1);
    expect_wr(4'b0001, 5'd4, {4{32'h1FF}});
    tick();
    drive_ld(1'b0, 5'd0, 32'h0);
    tick();

    // Backpressure: three FPU pushes while loads to element 21 hold the head
    drive_fpu(1'b1, 3'd5, 4'b0010, pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3));
    tick();
    drive_fpu(1'b1, 3'd5, 4'b0010, pack4(32'hB0, 32'hB1, 32'hB2, 32'hB3));
    chk("bp_ready_c1", {127'b0, fpu_ready_o}, 128'd1);
    for (int i = 0; i < 4; i++) begin
      drive_ld(1'b1, 5'd21, 32'h200 + 32'(i));
      expect_wr(4'b0010, 5'd21, {4{32'h200 + 32'(i)}});
      tick();
      drive_fpu(1'b1, 3'd7, 4'b1111, pack4(32'hC0, 32'hC1, 32'hC2, 32'hC3));
      chk("bp_ready_full", {127'b0, fpu_ready_o}, '0);
    end
    drive_ld(1'b1, 5'd21, 32'h2FF);
    chk("bp_forced_ld_ready", {127'b0, ld_ready_o}, '0);
    expect_wr(4'b0010, 5'd20, pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3));
    tick();
    chk("bp_ready_after_pop", {127'b0, fpu_ready_o}, 128'd1);
    expect_wr(4'b0010, 5'd21, {4{32'h2FF}});
    tick();
    drive_fpu(1'b0, 3'd0, 4'b0000, '0);
    drive_ld(1'b0, 5'd0, 32'h0);
    expect_wr(4'b0010, 5'd20, pack4(32'hB0, 32'hB1, 32'hB2, 32'hB3));
    expect_wr(4'b1111, 5'd28, pack4(32'hC0, 32'hC1, 32'hC2, 32'hC3));
    repeat (4) tick();
    chk("bp_drained_ready", {127'b0, fpu_ready_o}, 128'd1);

    // Zero-mask entry is dropped; a following entry still writes
    drive_fpu(1'b1, 3'd4, 4'b0000, pack4(32'hD0, 32'hD1, 32'hD2, 32'hD3));
    tick();
    dH = pack4(32'h70, 32'h71, 32'h72, 32'h73);
    drive_fpu(1'b1, 3'd0, 4'b1000, dH);
    expect_wr(4'b1000, 5'd0, dH);
    tick();
    drive_fpu(1'b0, 3'd0, 4'b0000, '0);
    chk("mask0_no_write_v", {124'b0, w_v_o}, '0);
    repeat (3) tick();

    // Reset mid-operation discards queued FPU entries and the pending write
    drive_fpu(1'b1, 3'd6, 4'b1111, pack4(32'h80, 32'h81, 32'h82, 32'h83));
    tick();
    drive_fpu(1'b1, 3'd6, 4'b0101, pack4(32'h90, 32'h91, 32'h92, 32'h93));
    tick();
    drive_fpu(1'b0, 3'd0, 4'b0000, '0);
    reset_n_i = 1'b0;
    #2;
    chk("midrst_w_v", {124'b0, w_v_o}, '0);
    tick();
    tick();
    reset_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_w_v", {124'b0, w_v_o}, '0);
      chk("post_rst_fpu_ready", {127'b0, fpu_ready_o}, 128'd1);
    end

    chk("scoreboard_empty", 128'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
